uart_frame_check: RTL and testbench

Parametrised UART receive frame checker. It generalises single-cycle start-bit glitch detection into a full per-frame validator: it oversamples the serial line, majority-votes three mid-bit samples, and sequences start, data, optional parity and 1–2 stop bits. It reports start glitches, parity errors and stop (framing) errors, and delivers the parallel data word. It sits between the RX input synchroniser and the RX data consumer, in the oversampling clock domain.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_bit_sampler.sv | 54 +++++
 rtl/uart_frame_check.sv | 142 ++++++++++++++
 tb/tb_uart_frame_check.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit tick counter with three mid-bit samples and a 2-of-3 vote.
module uart_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  run,
  input  logic                  start,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  bit_val,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  s0_q;
  logic                  s1_q;
  logic                  vote_q;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_vote;

  assign half    = p >> 1;
  assign last    = p - PRESCALE_W'(1);
  assign at_s0   = (cnt_q == half - PRESCALE_W'(1));
  assign at_s1   = (cnt_q == half);
  assign at_vote = (cnt_q == half + PRESCALE_W'(1));
  assign bit_end = run && (cnt_q == last);
  // At P=4 the vote tick is also the bit-end tick, so bypass the register.
  assign bit_val = at_vote ? maj3(s0_q, s1_q, rx_in) : vote_q;

  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      cnt_q  <= '0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      vote_q <= 1'b0;
    end else if (start) begin
      cnt_q <= PRESCALE_W'(1);
    end else if (!run) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= (cnt_q == last) ? '0 : cnt_q + PRESCALE_W'(1);
      if (at_s0)   s0_q   <= rx_in;
      if (at_s1)   s1_q   <= rx_in;
      if (at_vote) vote_q <= maj3(s0_q, s1_q, rx_in);
    end
  end

endmodule

// File: rtl/uart_frame_check.sv
// UART receive frame checker: start/data/parity/stop sequencing with error pulses.
module uart_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  rx_in,
  input  logic                  check_enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  start_glitch,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e             state_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  par_fail_q;
  logic                  start_det;
  logic                  run;
  logic                  bit_val;
  logic                  bit_end;

  assign start_det = (state_q == StIdle) && check_enable && !rx_in;
  assign run       = (state_q != StIdle) && check_enable;

  uart_bit_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk_based_on_prescale(clk_based_on_prescale),
    .asy_reset            (asy_reset),
    .run                  (run),
    .start                (start_det),
    .rx_in                (rx_in),
    .p                    (p_q),
    .bit_val              (bit_val),
    .bit_end              (bit_end)
  );

  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_q          <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= PAR_EVEN;
      par_fail_q   <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      start_glitch <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      start_glitch <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      if (!check_enable) begin
        state_q    <= StIdle;
        bit_cnt_q  <= '0;
        par_fail_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!rx_in) begin
              state_q    <= StStart;
              p_q        <= prescale & ~PRESCALE_W'(1);
              par_en_q   <= par_en;
              par_type_q <= par_type;
              bit_cnt_q  <= '0;
              par_fail_q <= 1'b0;
            end
          end
          StStart: begin
            if (bit_end) begin
              if (bit_val) begin
                start_glitch <= 1'b1;
                state_q      <= StIdle;
              end else begin
                state_q <= StData;
              end
            end
          end
          StData: begin
            if (bit_end) begin
              shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
              if (bit_cnt_q == LAST_DATA) begin
                bit_cnt_q <= '0;
                state_q   <= par_en_q ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StParity: begin
            if (bit_end) begin
              if (bit_val != ((^shift_q) ^ (par_type_q == PAR_ODD))) begin
                parity_error <= 1'b1;
                par_fail_q   <= 1'b1;
              end
              state_q <= StStop;
            end
          end
          StStop: begin
            if (bit_end) begin
              if (!bit_val) begin
                stop_error <= 1'b1;
                state_q    <= StIdle;
              end else if (bit_cnt_q == LAST_STOP) begin
                // A parity failure was already reported; the word is dropped.
                if (!par_fail_q) begin
                  p_data     <= shift_q;
                  data_valid <= 1'b1;
                end
                state_q <= StIdle;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check: one 1-stop-bit and one 2-stop-bit instance.
module tb_uart_frame_check;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          asy_reset = 1'b0;
  logic          rx1 = 1'b1;
  logic          rx2 = 1'b1;
  logic          check_enable = 1'b1;
  logic [PW-1:0] prescale = 6'd8;
  logic          par_en = 1'b0;
  logic          par_type = 1'b0;
  logic [DW-1:0] p_data1, p_data2;
  logic          dv1, sg1, pe1, se1, dv2, sg2, pe2, se2;

  always #5 clk = ~clk;

  uart_frame_check #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .STOP_BITS(1)) u_dut1 (
    .clk_based_on_prescale(clk), .asy_reset(asy_reset), .rx_in(rx1),
    .check_enable(check_enable), .prescale(prescale), .par_en(par_en), .par_type(par_type),
    .p_data(p_data1), .data_valid(dv1), .start_glitch(sg1), .parity_error(pe1),
    .stop_error(se1)
  );

  uart_frame_check #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .STOP_BITS(2)) u_dut2 (
    .clk_based_on_prescale(clk), .asy_reset(asy_reset), .rx_in(rx2),
    .check_enable(check_enable), .prescale(prescale), .par_en(par_en), .par_type(par_type),
    .p_data(p_data2), .data_valid(dv2), .start_glitch(sg2), .parity_error(pe2),
    .stop_error(se2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and timestamps, sampled on the falling edge.
  int n_dv1 = 0, n_sg1 = 0, n_pe1 = 0, n_se1 = 0, n_dv2 = 0, n_err2 = 0;
  int t_dv1 = 0, t_sg1 = 0, t_pe1 = 0, t_dv2 = 0, t_se2 = 0;
  always @(negedge clk) begin
    if (dv1) begin n_dv1++; t_dv1 = cyc; end
    if (sg1) begin n_sg1++; t_sg1 = cyc; end
    if (pe1) begin n_pe1++; t_pe1 = cyc; end
    if (se1) n_se1++;
    if (dv2) begin n_dv2++; t_dv2 = cyc; end
    if (se2) t_se2 = cyc;
    n_err2 += int'(sg2) + int'(pe2) + int'(se2);
  end

  int b_dv1, b_sg1, b_pe1, b_se1, b_dv2, b_err2;
  task automatic snap();
    b_dv1 = n_dv1; b_sg1 = n_sg1; b_pe1 = n_pe1; b_se1 = n_se1;
    b_dv2 = n_dv2; b_err2 = n_err2;
  endtask

  int checks = 0;
  int failures = 0;
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 1) rx1 = v;
    else rx2 = v;
  endtask

  // Frame config is perturbed after the start bit to prove it was latched.
  task automatic send_frame(input int sel, input logic [7:0] d, input int bp, input bit has_par,
                            input logic par_bit, input int nstop, input logic last_stop,
                            input int noise_bit, output int t0);
    logic [PW-1:0] pre_save;
    logic          pe_save, pt_save;
    drive(sel, 1'b0);
    t0 = cyc;
    tick(bp);
    pre_save = prescale; pe_save = par_en; pt_save = par_type;
    prescale = 6'd12; par_en = ~par_en; par_type = ~par_type;
    for (int i = 0; i < 8; i++) begin
      if (i == noise_bit) begin
        drive(sel, d[i]); tick(bp / 2);
        drive(sel, ~d[i]); tick(1);
        drive(sel, d[i]); tick(bp / 2 - 1);
      end else begin
        drive(sel, d[i]); tick(bp);
      end
    end
    if (has_par) begin drive(sel, par_bit); tick(bp); end
    for (int s = 0; s < nstop; s++) begin
      drive(sel, (s == nstop - 1) ? last_stop : 1'b1);
      tick(bp);
    end
    drive(sel, 1'b1);
    prescale = pre_save; par_en = pe_save; par_type = pt_save;
  endtask

  int t0, t0b;

  initial begin
    tick(4);
    check_eq("rst_p_data", {p_data2, p_data1}, 32'h0);
    check_eq("rst_pulses", {dv1, sg1, pe1, se1, dv2, sg2, pe2, se2}, 32'h0);
    asy_reset = 1'b1;
    snap();
    tick(100);
    check_eq("idle_pulses", n_dv1 + n_sg1 + n_pe1 + n_se1 + n_dv2 + n_err2, 0);
    check_eq("idle_p_data", p_data1, 32'h0);

    // 8N1 0xA5 at P=8
    snap();
    send_frame(1, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    tick(4);
    check_eq("a5_dv_cnt", n_dv1 - b_dv1, 1);
    check_eq("a5_latency", t_dv1 - t0, 80);
    check_eq("a5_p_data", p_data1, 32'hA5);
    check_eq("a5_errs", (n_sg1 - b_sg1) + (n_pe1 - b_pe1) + (n_se1 - b_se1), 0);

    // One-tick noise on the mid sample of data bit 2 is outvoted
    snap();
    send_frame(1, 8'h33, 8, 1'b0, 1'b0, 1, 1'b1, 2, t0);
    tick(4);
    check_eq("noise_dv_cnt", n_dv1 - b_dv1, 1);
    check_eq("noise_p_data", p_data1, 32'h33);

    // Minimum prescale P=4
    prescale = 6'd4;
    snap();
    send_frame(1, 8'hC3, 4, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    tick(4);
    check_eq("p4_latency", t_dv1 - t0, 40);
    check_eq("p4_p_data", p_data1, 32'hC3);

    // Even parity, wrong parity bit: 0x3C has four ones so parity bit should be 0
    prescale = 6'd16; par_en = 1'b1; par_type = 1'b0;
    snap();
    send_frame(1, 8'h3C, 16, 1'b1, 1'b1, 1, 1'b1, -1, t0);
    tick(4);
    check_eq("par_err_cnt", n_pe1 - b_pe1, 1);
    check_eq("par_err_time", t_pe1 - t0, 160);
    check_eq("par_no_dv", n_dv1 - b_dv1, 0);
    check_eq("par_p_data_held", p_data1, 32'hC3);

    // Odd parity correct; prescale LSB set must be ignored (17 -> 16)
    prescale = 6'd17; par_type = 1'b1;
    snap();
    send_frame(1, 8'h3C, 16, 1'b1, 1'b1, 1, 1'b1, -1, t0);
    tick(4);
    check_eq("odd_dv_cnt", n_dv1 - b_dv1, 1);
    check_eq("odd_latency", t_dv1 - t0, 176);
    check_eq("odd_p_data", p_data1, 32'h3C);
    check_eq("odd_no_pe", n_pe1 - b_pe1, 0);

    // Two-tick low glitch at P=8, then a clean frame
    prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    snap();
    drive(1, 1'b0);
    t0 = cyc;
    tick(2);
    drive(1, 1'b1);
    tick(12);
    check_eq("glitch_cnt", n_sg1 - b_sg1, 1);
    check_eq("glitch_time", t_sg1 - t0, 8);
    check_eq("glitch_no_dv", n_dv1 - b_dv1, 0);
    snap();
    send_frame(1, 8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    tick(4);
    check_eq("after_glitch_dv", n_dv1 - b_dv1, 1);
    check_eq("after_glitch_p_data", p_data1, 32'h5A);

    // STOP_BITS=2: second stop bit low, then a good frame
    snap();
    send_frame(2, 8'h81, 8, 1'b0, 1'b0, 2, 1'b0, -1, t0);
    tick(4);
    check_eq("stop2_err_time", t_se2 - t0, 88);
    check_eq("stop2_err_cnt", n_err2 - b_err2, 1);
    check_eq("stop2_no_dv", n_dv2 - b_dv2, 0);
    snap();
    send_frame(2, 8'h42, 8, 1'b0, 1'b0, 2, 1'b1, -1, t0);
    tick(4);
    check_eq("stop2_dv_cnt", n_dv2 - b_dv2, 1);
    check_eq("stop2_latency", t_dv2 - t0, 88);
    check_eq("stop2_p_data", p_data2, 32'h42);

    // Enable dropped during data bit 3 of 0xF8; remaining line stays high
    snap();
    drive(1, 1'b0); tick(8);
    tick(24);
    drive(1, 1'b1); tick(3);
    check_enable = 1'b0; tick(2);
    check_enable = 1'b1; tick(60);
    check_eq("abort_pulses", (n_dv1 - b_dv1) + (n_sg1 - b_sg1) + (n_pe1 - b_pe1)
             + (n_se1 - b_se1), 0);
    check_eq("abort_p_data", p_data1, 32'h5A);

    // Back-to-back 0xFF frames
    snap();
    send_frame(1, 8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    send_frame(1, 8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, -1, t0b);
    tick(4);
    check_eq("b2b_dv_cnt", n_dv1 - b_dv1, 2);
    check_eq("b2b_latency", t_dv1 - t0b, 80);
    check_eq("b2b_p_data", p_data1, 32'hFF);

    // Reset mid-frame clears everything with no pulse
    snap();
    drive(1, 1'b0); tick(28);
    asy_reset = 1'b0; tick(1);
    asy_reset = 1'b1; drive(1, 1'b1); tick(80);
    check_eq("midrst_p_data", p_data1, 32'h0);
    check_eq("midrst_pulses", (n_dv1 - b_dv1) + (n_sg1 - b_sg1) + (n_pe1 - b_pe1)
             + (n_se1 - b_se1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
